// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared opcode/funct constants, FSM encodings and the legality
//            check used by the comparison arbiter and its comparator.
// Revision : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Opcode / funct encodings of the three supported compare instructions
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SEQI  = 6'b001011;

  // Arbiter FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // True for slt (R-type), slti and seqi; everything else is illegal
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    return ((opcode == OP_RTYPE) && (funct == FN_SLT)) ||
           (opcode == OP_SLTI) || (opcode == OP_SEQI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_unit.sv
`default_nettype none
// ============================================================================
// Module   : comparator_unit
// Purpose  : Combinational compare datapath: signed less-than for slt/slti,
//            equality for seqi, zero for any unsupported opcode/funct pair.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_unit
  import cmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [31:0] result
);

  // Select the comparison by instruction; illegal encodings yield 0
  always_comb begin
    result = '0;
    if (opcode == OP_SEQI) begin
      result = {31'd0, (a == b)};
    end else if (is_legal(opcode, funct)) begin
      result = {31'd0, ($signed(a) < $signed(b))};
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin picker. Grants the first set
//            request at or above rr_ptr, wrapping to the lowest set request.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] w_sel_hi;
  logic [ID_W-1:0] w_sel_lo;
  logic            w_hi_found;

  // Scan downward so the last hit is the lowest index; the "hi" pick only
  // considers requests at or above the pointer, "lo" is the wrap-around
  always_comb begin
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_sel_lo = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          w_sel_hi   = ID_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
  end

  // Convert the winning index to a one-hot grant
  always_comb begin
    any_valid = |req;
    grant_idx = w_hi_found ? w_sel_hi : w_sel_lo;
    grant     = any_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_arbiter
// Purpose  : Shares one comparator_unit among NUM_REQ requesters. A request
//            is picked round-robin, its operands latched, evaluated in one
//            cycle and returned with its requester ID over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*6-1:0]  req_opcode,
  input  logic [NUM_REQ*6-1:0]  req_funct,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_illegal,
  output logic                  busy,
  output logic [CNT_W-1:0]      cmp_count
);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any_valid;

  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [5:0]         w_sel_op;
  logic [5:0]         w_sel_fn;

  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [5:0]         r_opcode;
  logic [5:0]         r_funct;
  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_result;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        w_cmp_result;
  logic               w_accept;
  logic               w_complete;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_valid (w_any_valid)
  );

  comparator_unit u_comparator_unit (
    .a      (r_a),
    .b      (r_b),
    .opcode (r_opcode),
    .funct  (r_funct),
    .result (w_cmp_result)
  );

  assign w_accept   = (r_state == S_IDLE) && w_any_valid;
  assign w_complete = (r_state == S_RESP) && rsp_ready;

  // Steer the granted requester's payload slice toward the operand latches
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    w_sel_fn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a  = req_a[32*i +: 32];
        w_sel_b  = req_b[32*i +: 32];
        w_sel_op = req_opcode[6*i +: 6];
        w_sel_fn = req_funct[6*i +: 6];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: one grant, one evaluate cycle, then hold until consumed
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_valid) w_next_state = S_EVAL;
      S_EVAL:  w_next_state = S_RESP;
      S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs; grants are suppressed while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  if (rst_n) req_ready = w_grant;
      S_EVAL:  busy = 1'b1;
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Capture the granted request and advance the round-robin pointer past it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_a      <= w_sel_a;
      r_b      <= w_sel_b;
      r_opcode <= w_sel_op;
      r_funct  <= w_sel_fn;
      r_id     <= w_grant_idx;
      r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));
    end
  end

  // Register the comparison result and legality flag at the end of EVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (r_state == S_EVAL) begin
      r_result  <= w_cmp_result;
      r_illegal <= !is_legal(r_opcode, r_funct);
    end
  end

  // Count completed response handshakes, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_complete) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign rsp_id      = r_id;
  assign rsp_result  = r_result;
  assign rsp_illegal = r_illegal;
  assign cmp_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_arbiter
// Purpose  : Scoreboard bench for cmp_arbiter: directed scenarios plus a
//            randomized phase, checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*6-1:0]  req_opcode;
  logic [NUM_REQ*6-1:0]  req_funct;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_illegal;
  logic                  busy;
  logic [CNT_W-1:0]      cmp_count;

  cmp_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_opcode  (req_opcode),
    .req_funct   (req_funct),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_illegal (rsp_illegal),
    .busy        (busy),
    .cmp_count   (cmp_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] result;
    logic        illegal;
    int          acc_cyc;
  } exp_t;

  exp_t expq[$];

  // Requester-side pending requests
  logic        pend [NUM_REQ];
  logic [31:0] pa   [NUM_REQ];
  logic [31:0] pb   [NUM_REQ];
  logic [5:0]  po   [NUM_REQ];
  logic [5:0]  pf   [NUM_REQ];

  // Reference model state
  int               last_g;
  int               acc_cyc;
  int               done_cyc;
  bit               inflight;
  logic [CNT_W-1:0] exp_count;
  int               grants [NUM_REQ];
  int               granted;
  bit               prev_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_legal(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'd0 && fn == 6'd42) || op == 6'd10 || op == 6'd11;
  endfunction

  // seqi: equality; slt/slti: signed less-than; anything else: 0
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd11) return (a == b) ? 32'd1 : 32'd0;
    if (ref_legal(op, fn)) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return 32'd0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]         = pend[i];
      req_a[32*i +: 32]    = pa[i];
      req_b[32*i +: 32]    = pb[i];
      req_opcode[6*i +: 6] = po[i];
      req_funct[6*i +: 6]  = pf[i];
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [5:0] fn);
    pend[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
    po[i] = op;
    pf[i] = fn;
  endtask

  task automatic new_req(input int i);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 2) == 0) ? a : $urandom;
    case ($urandom_range(0, 3))
      0:       set_req(i, a, b, 6'd0, 6'd42);
      1:       set_req(i, a, b, 6'd10, 6'($urandom));
      2:       set_req(i, a, b, 6'd11, 6'($urandom));
      default: set_req(i, a, b, 6'($urandom), 6'($urandom));
    endcase
  endtask

  function automatic bit pend_any();
    for (int i = 0; i < NUM_REQ; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_model();
    expq.delete();
    inflight  = 1'b0;
    last_g    = NUM_REQ - 1;
    acc_cyc   = -1;
    done_cyc  = -1;
    exp_count = '0;
  endtask

  // One clock of stimulus: predict the grant, compare, record acceptance
  task automatic step();
    bit                 idle;
    int                 eg;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    idle = !inflight || (done_cyc > acc_cyc && done_cyc < cyc);
    check("busy", busy, !idle);
    eg = -1;
    if (idle) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (last_g + k) % NUM_REQ;
        if (pend[i] && eg < 0) eg = i;
      end
    end
    exp_rdy = '0;
    if (eg >= 0) exp_rdy[eg] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    granted = -1;
    if (eg >= 0) begin
      expq.push_back('{eg, ref_result(pa[eg], pb[eg], po[eg], pf[eg]),
                       !ref_legal(po[eg], pf[eg]), cyc});
      last_g   = eg;
      inflight = 1'b1;
      acc_cyc  = cyc;
      grants[eg]++;
      granted  = eg;
    end
    @(posedge clk);
    #1;
    if (granted >= 0) pend[granted] = 1'b0;
    drive_inputs();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((pend_any() || expq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", {63'd0, (pend_any() || expq.size() != 0)}, 64'd0);
  endtask

  // Response monitor: compare each presented response with the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cmp_count", cmp_count, exp_count);
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          if (!prev_valid) check("latency", cyc - expq[0].acc_cyc, 2);
          check("rsp_id", rsp_id, expq[0].id);
          check("rsp_result", rsp_result, expq[0].result);
          check("rsp_illegal", rsp_illegal, expq[0].illegal);
          if (rsp_ready) begin
            void'(expq.pop_front());
            exp_count = exp_count + CNT_W'(1);
            done_cyc  = cyc;
          end
        end
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    prev_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0; pf[i] = '0;
      grants[i] = 0;
    end
    reset_model();
    drive_inputs();

    // Reset values
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_count", cmp_count, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_illegal", rsp_illegal, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single slti request: -1 < 1
    set_req(0, 32'hFFFF_FFFF, 32'd1, 6'b001010, 6'd0);
    drive_inputs();
    run_until_idle(20);
    step();

    // All four requesting continuously: round-robin fairness over 8 grants
    for (int i = 0; i < NUM_REQ; i++) grants[i] = 0;
    for (int i = 0; i < NUM_REQ; i++) new_req(i);
    drive_inputs();
    for (int n = 0; n < 100; n++) begin
      int total;
      step();
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) total += grants[i];
      if (total >= 2 * NUM_REQ) break;
      if (granted >= 0) new_req(granted);
      drive_inputs();
    end
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) check("fair_grants", grants[i], 2);
    run_until_idle(20);

    // seqi on requester 2: equal then differing operands
    set_req(2, 32'h1234_5678, 32'h1234_5678, 6'b001011, 6'd0);
    drive_inputs();
    run_until_idle(20);
    set_req(2, 32'h1234_5678, 32'h1234_5679, 6'b001011, 6'd0);
    drive_inputs();
    run_until_idle(20);

    // Illegal R-type funct (add)
    set_req(1, 32'd1, 32'd5, 6'b000000, 6'b100000);
    drive_inputs();
    run_until_idle(20);

    // Backpressure: response held for many cycles, no further grants
    rsp_ready = 1'b0;
    set_req(3, 32'd7, 32'hFFFF_FFF0, 6'b000000, 6'b101010);
    drive_inputs();
    step();
    set_req(0, 32'd1, 32'd2, 6'b001010, 6'd0);
    set_req(1, 32'd3, 32'd3, 6'b001011, 6'd0);
    drive_inputs();
    repeat (12) step();
    rsp_ready = 1'b1;
    run_until_idle(30);

    // Reset while a comparison is in EVAL
    set_req(2, 32'd0, 32'd1, 6'b001010, 6'd0);
    drive_inputs();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmp_count", cmp_count, 0);
    check("midrst_req_ready", req_ready, 0);
    reset_model();
    set_req(1, 32'd9, 32'd9, 6'b001011, 6'd0);
    set_req(3, 32'd4, 32'd2, 6'b001010, 6'd0);
    drive_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until_idle(30);

    // Randomized traffic with random backpressure and request withdrawal
    for (int n = 0; n < 1500; n++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if ($urandom_range(0, 31) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
    end
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    rsp_ready = 1'b1;
    drive_inputs();
    run_until_idle(50);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares a single comparator_unit instance among NUM_REQ requesters, for example the issue slot, the branch-resolve path and the debug port.
- Selects one request at a time by round-robin and latches its operands.
- Sequences the comparison through a 3-state FSM and returns the registered result, tagged with the requester ID, over a valid/ready response handshake.
- Sits between the decode/issue logic and the comparison datapath of the Mini-MIPS core.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ID_W, 2, requester ID width; must be at least clog2(NUM_REQ).
- CNT_W, 16, width of the completed-compare counter.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant pulse; a request is accepted in the cycle where valid and ready are both 1.
- req_a  input  NUM_REQ*32  packed operand A; slice i is [32*i+31:32*i].
- req_b  input  NUM_REQ*32  packed operand B.
- req_opcode  input  NUM_REQ*6  packed opcode.
- req_funct  input  NUM_REQ*6  packed funct.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester being answered.
- rsp_result  output  32  comparison result, 0 or 1.
- rsp_illegal  output  1  1 when the opcode/funct pair is not slt, slti or seqi.
- busy  output  1  1 whenever state is not IDLE.
- cmp_count  output  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE, rr_ptr=0, all req_ready=0, rsp_valid=0.
  - rsp_id=0, rsp_result=0, rsp_illegal=0, busy=0, cmp_count=0.
  - Operand latches clear to 0.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid index found searching from rr_ptr upward, wrapping past NUM_REQ-1 to 0.
  - req_ready[grant]=1 combinationally in this cycle only.
  - On the clock edge: latch the granted a/b/opcode/funct and the ID, set rr_ptr=(grant+1) mod NUM_REQ, go to EVAL.
  - With no valid requests: req_ready=0, rr_ptr unchanged.
- EVAL:
  - Latched operands drive comparator_unit.
  - On the clock edge: register its output into rsp_result, and register rsp_illegal. rsp_illegal is 1 unless (opcode=000000 and funct=101010), opcode=001010 or opcode=001011.
  - Then assert rsp_valid and go to RESP. req_ready=0 throughout EVAL.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_illegal stay stable until the handshake completes.
  - On rsp_valid and rsp_ready: rsp_valid drops to 0, cmp_count increments, go to IDLE.
  - req_ready=0 throughout RESP.
- Latency: grant cycle in IDLE, one EVAL cycle, then rsp_valid rises in the next cycle, so 2 cycles from acceptance to rsp_valid.
  - Minimum issue interval is 3 cycles when rsp_ready is held at 1.
- Illegal requests still complete with result 0 and rsp_illegal=1. They count in cmp_count and advance rr_ptr.
- Requesters must hold valid and payload until they are granted. A requester may drop req_valid before being granted without error.
- Simultaneous requests: exactly one grant per IDLE cycle. Ties are resolved by rr_ptr, never by fixed priority.
- rsp_ready held low: the FSM stays in RESP indefinitely and no new grants are issued.
- cmp_count at all ones wraps to 0 on the next completion.
- Reset mid-operation: any in-flight comparison is discarded and no response is emitted. A requester granted before the reset must re-request.

Decomposition:
- Shared package cmp_pkg:
  - Opcode/funct constants OP_RTYPE=6'b000000, FN_SLT=6'b101010, OP_SLTI=6'b001010, OP_SEQI=6'b001011.
  - FSM state encodings S_IDLE, S_EVAL, S_RESP as 2-bit localparams.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ-wide req vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - Purely combinational; reusable for other shared units.
- cmp_arbiter instantiates rr_arbiter and comparator_unit, and holds the FSM, latches and counter.

Test Plan:
- Single request: req_valid=0001, a=0xFFFFFFFF, b=1, opcode=001010 -> req_ready=0001 for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=1, rsp_illegal=0; cmp_count=1 after the handshake.
- All four requesting continuously with rsp_ready=1 -> grant order 0,1,2,3,0; each requester gets exactly 1 grant per 4 responses.
- seqi on requester 2, a=b=0x12345678, opcode=001011 -> rsp_id=2, rsp_result=1. With b=0x12345679 -> rsp_result=0.
- Illegal request: opcode=000000, funct=100000 -> rsp_result=0, rsp_illegal=1, cmp_count increments.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_result stable; req_ready=0 throughout; completion follows rsp_ready=1.
- Reset during EVAL: rst_n low for 1 cycle -> rsp_valid=0, busy=0, cmp_count=0 and rr_ptr=0 immediately; the next grant goes to the lowest valid index.
